// File: rtl/alu_seg_display.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seg_display
//  Purpose  : ALU output stage. Converts the registered 9-bit result to BCD
//             with a sequential shift-add-3 engine and drives a 4-digit,
//             common-anode, time-multiplexed seven-segment display. The
//             leftmost digit shows the ALU status glyph.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seg_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,          // active-high synchronous reset
  input  logic [8:0] c_plus_carry,
  input  logic [3:0] letters,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t      state;
  logic [12:0] shadow;      // {c_plus_carry, letters} last captured
  logic [20:0] sreg;        // {hundreds, tens, ones, binary}
  logic [20:0] sreg_adj;    // sreg with the add-3 correction applied
  logic [3:0]  cnt;
  logic [3:0]  disp_h, disp_t, disp_o, disp_letter;
  logic        disp_carry;
  logic [RW-1:0] refresh;
  logic [1:0]  idx;
  logic [6:0]  seg_next;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0: digit_glyph = 7'h40;
      4'd1: digit_glyph = 7'h79;
      4'd2: digit_glyph = 7'h24;
      4'd3: digit_glyph = 7'h30;
      4'd4: digit_glyph = 7'h19;
      4'd5: digit_glyph = 7'h12;
      4'd6: digit_glyph = 7'h02;
      4'd7: digit_glyph = 7'h78;
      4'd8: digit_glyph = 7'h00;
      4'd9: digit_glyph = 7'h10;
      default: digit_glyph = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] letter_glyph(input logic [3:0] l);
    case (l)
      4'h0:                             letter_glyph = 7'h7F;
      4'hA:                             letter_glyph = 7'h08;
      4'hB:                             letter_glyph = 7'h03;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: letter_glyph = digit_glyph(l);
      default:                          letter_glyph = 7'h3F;
    endcase
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
  always_comb begin
    sreg_adj = sreg;
    if (sreg[12:9]  >= 4'd5) sreg_adj[12:9]  = sreg[12:9]  + 4'd3;
    if (sreg[16:13] >= 4'd5) sreg_adj[16:13] = sreg[16:13] + 4'd3;
    if (sreg[20:17] >= 4'd5) sreg_adj[20:17] = sreg[20:17] + 4'd3;
  end

  // Capture / convert / load sequencer; display regs change only in LOAD
  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= IDLE;
      shadow      <= '0;
      sreg        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      disp_h      <= '0;
      disp_t      <= '0;
      disp_o      <= '0;
      disp_letter <= '0;
      disp_carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ({c_plus_carry, letters} != shadow) begin
            shadow <= {c_plus_carry, letters};
            sreg   <= {12'b0, c_plus_carry};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          sreg <= {sreg_adj[19:0], 1'b0};
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd8) state <= LOAD;
        end
        LOAD: begin
          disp_h      <= sreg[20:17];
          disp_t      <= sreg[16:13];
          disp_o      <= sreg[12:9];
          disp_letter <= shadow[3:0];
          disp_carry  <= shadow[12];
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh prescaler and digit scan index
  always_ff @(posedge clk) begin
    if (rstn) begin
      refresh <= '0;
      idx     <= '0;
    end else if (refresh == REF_MAX) begin
      refresh <= '0;
      idx     <= idx + 2'd1;
    end else begin
      refresh <= refresh + RW'(1);
    end
  end

  // Glyph for the currently scanned digit, with leading-zero blanking
  always_comb begin
    seg_next = 7'h7F;
    case (idx)
      2'd0: seg_next = digit_glyph(disp_o);
      2'd1: seg_next = (LZ_BLANK && disp_h == 4'd0 && disp_t == 4'd0) ? 7'h7F
                                                                    : digit_glyph(disp_t);
      2'd2: seg_next = (LZ_BLANK && disp_h == 4'd0) ? 7'h7F : digit_glyph(disp_h);
      2'd3: seg_next = letter_glyph(disp_letter);
      default: seg_next = 7'h7F;
    endcase
  end

  // Registered display drive, one cycle behind the scan index
  always_ff @(posedge clk) begin
    if (rstn) begin
      seg <= 7'h7F;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= ~(4'b0001 << idx);
      dp  <= ~((idx == 2'd0) && disp_carry);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seg_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seg_display
//  Purpose  : Self-checking bench for alu_seg_display (REFRESH_DIV=4), with
//             one instance blanking leading zeros and one not.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seg_display;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [8:0] c_plus_carry = '0;
  logic [3:0] letters = '0;
  logic [6:0] seg1, seg0;
  logic [3:0] an1, an0;
  logic       dp1, dp0, busy1, busy0;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;      // edges since reset release
  int cur_val = 0;      // value the display should currently show
  int cur_let = 0;      // letter code the display should currently show

  alu_seg_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .c_plus_carry(c_plus_carry), .letters(letters),
    .seg(seg1), .an(an1), .dp(dp1), .busy(busy1));

  alu_seg_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .c_plus_carry(c_plus_carry), .letters(letters),
    .seg(seg0), .an(an0), .dp(dp0), .busy(busy0));

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= rstn ? 0 : ecnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] dig(input int d);
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic logic [6:0] let_glyph(input int l);
    if (l == 0)                 return 7'h7F;
    if (l == 10)                return 7'h08;
    if (l == 11)                return 7'h03;
    if (l >= 1 && l <= 6)       return dig(l);
    return 7'h3F;
  endfunction

  function automatic logic [6:0] exp_seg(input int i, input int v, input int l, input bit lz);
    case (i)
      0: return dig(v % 10);
      1: return (lz && v < 10)  ? 7'h7F : dig((v / 10) % 10);
      2: return (lz && v < 100) ? 7'h7F : dig(v / 100);
      default: return let_glyph(l);
    endcase
  endfunction

  // Compare both instances against the model for the digit scanned now
  task automatic scan_now();
    int i;
    logic [3:0] ean;
    logic       edp;
    i   = ((ecnt - 1) / 4) % 4;
    ean = ~(4'b0001 << i);
    edp = !(i == 0 && cur_val >= 256);
    check("an_lz1",  an1,  ean);
    check("seg_lz1", seg1, exp_seg(i, cur_val, cur_let, 1'b1));
    check("dp_lz1",  dp1,  edp);
    check("an_lz0",  an0,  ean);
    check("seg_lz0", seg0, exp_seg(i, cur_val, cur_let, 1'b0));
    check("dp_lz0",  dp0,  edp);
  endtask

  task automatic check_reset_out();
    check("rst_seg",  seg1,  7'h7F);
    check("rst_an",   an1,   4'hF);
    check("rst_dp",   dp1,   1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_busy0", busy0, 1'b0);
  endtask

  task automatic scan_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check("idle_busy", busy1, 1'b0);
      scan_now();
    end
  endtask

  // Apply inputs and follow one conversion. Optionally change the inputs
  // at busy cycle chg_at, or assert reset at busy cycle rst_at.
  task automatic run_conv(input int v, input int l, input int chg_at,
                          input int v2, input int l2, input int rst_at);
    int n;
    c_plus_carry = v[8:0];
    letters      = l[3:0];
    tick();
    check("busy_rise", busy1, 1'b1);
    check("busy_rise0", busy0, 1'b1);
    scan_now();
    n = 1;
    while (busy1 && n < 40) begin
      if (n == chg_at) begin
        c_plus_carry = v2[8:0];
        letters      = l2[3:0];
      end
      if (n == rst_at) begin
        rstn = 1'b1;
        tick();
        check_reset_out();
        cur_val = 0;
        cur_let = 0;
        rstn = 1'b0;
        return;
      end
      tick();
      scan_now();
      if (busy1) n++;
    end
    check("busy_len", n, 10);
    cur_val = v;
    cur_let = l;
  endtask

  initial begin
    int v, l, pv, pl;

    // 1. reset held for three edges, then release
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_reset_out();
    end
    rstn = 1'b0;
    tick();
    check("rel_an", an1, 4'b1110);
    check("rel_seg", seg1, 7'h40);
    check("rel_busy", busy1, 1'b0);
    scan_cycles(8);

    // 2. 255 / letter 1
    run_conv(255, 1, 0, 0, 0, 0);
    scan_cycles(16);

    // 3. borrow result shown unsigned, carry on dp
    run_conv(9'h1FE, 2, 0, 0, 0, 0);
    scan_cycles(16);

    // 4. leading-zero blanking
    run_conv(7, 10, 0, 0, 0, 0);
    scan_cycles(16);

    // 5. input change during conversion: last value wins
    run_conv(255, 1, 3, 100, 5, 0);
    run_conv(100, 5, 0, 0, 0, 0);
    scan_cycles(16);

    // 6. reset on the fifth conversion cycle, then recapture
    run_conv(255, 1, 0, 0, 0, 5);
    run_conv(255, 1, 0, 0, 0, 0);
    scan_cycles(16);

    // boundary values
    run_conv(0, 11, 0, 0, 0, 0);   scan_cycles(16);
    run_conv(10, 0, 0, 0, 0, 0);   scan_cycles(16);
    run_conv(99, 7, 0, 0, 0, 0);   scan_cycles(16);
    run_conv(256, 6, 0, 0, 0, 0);  scan_cycles(16);
    run_conv(511, 15, 0, 0, 0, 0); scan_cycles(16);

    // randomized values and letter codes
    pv = 511;
    pl = 15;
    for (int it = 0; it < 25; it++) begin
      v = int'($urandom_range(0, 511));
      l = int'($urandom_range(0, 15));
      if (v == pv && l == pl) v = v ^ 1;
      run_conv(v, l, 0, 0, 0, 0);
      scan_cycles(16);
      pv = v;
      pl = l;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seg_display.md
Name: alu_seg_display

Overview:
- Output stage directly downstream of the 8-bit ALU. Consumes the ALU's registered 9-bit result/carry word and 4-bit status letter code.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Converts the 9-bit result to 3-digit BCD with a sequential shift-add-3 FSM. Shows the status glyph on the leftmost digit.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays enabled (>= 2).
- LZ_BLANK, 1: when 1, leading-zero hundreds/tens digits are blanked.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-high reset (rstn=1 resets)
- c_plus_carry  in  9  ALU result, bit 8 = carry/borrow
- letters  in  4  ALU status code (0 idle, A/B operand load, 1..6 opcode)
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  4  digit enables, active-low, an[0] = rightmost
- dp  out  1  decimal point, active-low
- busy  out  1  high while BCD conversion is in progress

Behaviour:
- Reset: sampled on the clk edge while rstn=1.
  - Output values: seg=7'h7F, an=4'hF, dp=1, busy=0.
  - All internal registers cleared: shadow, BCD, scan index, refresh counter. FSM goes to IDLE.
  - Reset mid-conversion abandons the conversion; no partial BCD is ever displayed.
- Capture (IDLE only):
  - Each edge, compare {c_plus_carry, letters} with the shadow register.
  - If they differ: shadow <= inputs, shift reg <= {12'b0, c_plus_carry}, iteration cnt <= 0, go to CONV, busy <= 1.
  - Input changes while not in IDLE are ignored. They are re-compared on return to IDLE, so the last value always wins.
- CONV (exactly 9 edges):
  - Each edge, for each BCD nibble (ones, tens, hundreds): add 3 if the nibble is >= 5, then shift the whole 21-bit reg left by 1. cnt increments.
  - On the edge with cnt==8, go to LOAD.
- LOAD (1 edge):
  - Display regs <= hundreds/tens/ones nibbles, shadow letter and shadow carry.
  - busy <= 0, go to IDLE.
- Latency: input change sampled at edge E0 -> busy=1 after E0 -> display regs valid after E10 -> busy=0 after E10.
- Range: 0..511. A 9-bit borrow result is shown as an unsigned value (e.g. 0x1FE shows 510).
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the 2-bit scan index increments 0->1->2->3->0.
- Digit content:
  - idx0 = ones (never blanked).
  - idx1 = tens; blanked if LZ_BLANK and hundreds==0 and tens==0.
  - idx2 = hundreds; blanked if LZ_BLANK and hundreds==0.
  - idx3 = letter glyph.
- seg/an/dp are registered, so they lag the scan index by one cycle.
  - an = one-hot-low of idx.
  - dp = 0 only on idx0 when the displayed carry bit is 1; otherwise dp = 1.
- Glyphs (seg):
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Letters: 'A'=08, 'b'=03, '-'=3F, blank=7F.
- Letter map:
  - 0 -> blank, 4'hA -> 'A', 4'hB -> 'b', 1..6 -> matching digit glyph.
  - Any other code -> '-'.
- First cycle after reset release: an=4'b1110, seg=7'h40 (ones digit '0').

Test Plan:
1. Reset (REFRESH_DIV=4): hold rstn 3 cycles -> seg=7F, an=F, dp=1, busy=0. One edge after release -> an=1110, seg=40.
2. Apply c_plus_carry=255, letters=1 -> busy high for exactly 10 cycles. Scan then gives: an=1110 seg=12 ('5'), 1101 seg=12 ('5'), 1011 seg=24 ('2'), 0111 seg=79 ('1'). dp=1 throughout.
3. Apply c_plus_carry=9'h1FE, letters=2 -> digits read 0,1,5 (ones to hundreds), letter '2' (seg=24). dp=0 only while an=1110.
4. Apply c_plus_carry=7, letters=4'hA -> idx1 and idx2 seg=7F, idx0 seg=78, idx3 seg=08. With LZ_BLANK=0 -> idx1 and idx2 seg=40.
5. Apply 255/1, then change to 100/5 on the 3rd busy cycle -> display shows 255 after E10. busy drops for 1 cycle, a second conversion starts, and the final display is 100 with letter '5'.
6. Assert rstn on the 5th CONV cycle -> next edge: seg=7F, an=F, busy=0. After release the display shows '0' with blank letter (no stale BCD). Inputs held at 255/1 are then re-captured: conversion restarts and 255 is displayed 10 cycles later.
